// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin codes, FSM states and
// a coin-value decode helper.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_ONE    = 2'b01,
    COIN_TWO    = 2'b10,
    COIN_CANCEL = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    SOLD_OUT = 2'b10
  } state_e;

  // Monetary value of a coin code; cancel and none carry no value.
  function automatic logic [1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_ONE: return 2'd1;
      COIN_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock_ctr.sv
// Inventory counter: loads STOCK_INIT on reset, STOCK_MAX on load,
// decrements on dec but never below zero. load dominates dec.
module vend_stock_ctr
  import vend_pkg::*;
#(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  parameter int STOCK_MAX  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec,
  input  logic               load,
  output logic [STOCK_W-1:0] stock_cnt,
  output logic               sold_out
);

  // Stock register: refill wins, otherwise saturating decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      stock_cnt <= STOCK_W'(STOCK_INIT);
    end else if (load) begin
      stock_cnt <= STOCK_W'(STOCK_MAX);
    end else if (dec && (stock_cnt != '0)) begin
      stock_cnt <= stock_cnt - 1'b1;
    end
  end

  assign sold_out = (stock_cnt == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Drink-vending controller: accumulates coin credit, dispenses one drink per
// PRICE units, returns change/refunds and rejects coins while sold out.
// Optional macro VEND_CREDIT_CARRY_EN keeps purchase excess as credit
// instead of returning it on back.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 4,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  parameter int STOCK_MAX  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                refill,
  output logic                drink,
  output logic [CREDIT_W-1:0] back,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock_cnt,
  output logic                sold_out
);

  // Reject parameter sets the datapath cannot represent.
  generate
    if ((PRICE < 2) || (PRICE > (1 << CREDIT_W) - 2) ||
        (STOCK_INIT < 0) || (STOCK_INIT > STOCK_MAX) ||
        (STOCK_MAX >= (1 << STOCK_W))) begin : g_param_check
      $fatal(1, "vend_ctrl: illegal parameter combination");
    end
  endgenerate

  localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_W    = CREDIT_W'(PRICE);
  // A zero initial stock must start in SOLD_OUT so coins are rejected.
  localparam state_e              STATE_INIT = (STOCK_INIT == 0) ? SOLD_OUT : IDLE;

  state_e              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] back_nxt;
  logic                drink_nxt;
  logic                purchase;
  logic [1:0]          coin_v;
  logic [CREDIT_W:0]   sum;
  logic [STOCK_W-1:0]  stock_nxt;

  vend_stock_ctr #(
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT),
    .STOCK_MAX (STOCK_MAX)
  ) u_stock (
    .clk      (clk),
    .reset    (reset),
    .dec      (purchase),
    .load     (refill),
    .stock_cnt(stock_cnt),
    .sold_out (sold_out)
  );

  // State, credit and the one-cycle dispense/change outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= STATE_INIT;
      credit <= '0;
      drink  <= 1'b0;
      back   <= '0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      drink  <= drink_nxt;
      back   <= back_nxt;
    end
  end

  // Coin evaluation against the pre-refill stock, then next-state from the
  // resulting credit and stock.
  always_comb begin
    credit_nxt = credit;
    back_nxt   = '0;
    drink_nxt  = 1'b0;
    purchase   = 1'b0;
    coin_v     = coin_value(coin);
    sum        = {1'b0, credit} + (CREDIT_W + 1)'(coin_v);

    if (coin == COIN_CANCEL) begin
      back_nxt   = credit;
      credit_nxt = '0;
    end else if (coin_v != 2'd0) begin
      if (state == SOLD_OUT) begin
        back_nxt = CREDIT_W'(coin_v);
      end else if (sum >= PRICE_X) begin
        drink_nxt = 1'b1;
        purchase  = 1'b1;
`ifdef VEND_CREDIT_CARRY_EN
        credit_nxt = sum[CREDIT_W-1:0] - PRICE_W;
`else
        back_nxt   = sum[CREDIT_W-1:0] - PRICE_W;
        credit_nxt = '0;
`endif
      end else begin
        credit_nxt = sum[CREDIT_W-1:0];
      end
    end

    if (refill) begin
      stock_nxt = STOCK_W'(STOCK_MAX);
    end else if (purchase && (stock_cnt != '0)) begin
      stock_nxt = stock_cnt - 1'b1;
    end else begin
      stock_nxt = stock_cnt;
    end

    if (stock_nxt == '0) begin
      state_nxt = SOLD_OUT;
    end else if (credit_nxt == '0) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = COLLECT;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with default parameters (PRICE=4,
// STOCK_INIT=2, STOCK_MAX=8). Honours VEND_CREDIT_CARRY_EN when defined.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin;
  logic       refill;
  logic       drink;
  logic [3:0] back;
  logic [3:0] credit;
  logic [3:0] stock_cnt;
  logic       sold_out;

  int checks = 0;
  int errors = 0;

  vend_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin),
    .refill   (refill),
    .drink    (drink),
    .back     (back),
    .credit   (credit),
    .stock_cnt(stock_cnt),
    .sold_out (sold_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, then settle just after it.
  task automatic step(input logic [1:0] c, input logic r);
    coin   = c;
    refill = r;
    @(posedge clk);
    #1;
    coin   = 2'b00;
    refill = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2'b00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int d, input int b, input int cr, input int st);
    check({tag, ".drink"}, 32'(drink), d);
    check({tag, ".back"}, 32'(back), b);
    check({tag, ".credit"}, 32'(credit), cr);
    check({tag, ".stock"}, 32'(stock_cnt), st);
  endtask

  initial begin
    reset  = 1'b1;
    coin   = 2'b00;
    refill = 1'b0;

    // Reset state
    do_reset();
    chk_out("rst", 0, 0, 0, 2);
    check("rst.sold_out", 32'(sold_out), 0);

    // 1: 1 + 1 + 2 = exact price
    step(2'b01, 1'b0);
    check("t1.credit1", 32'(credit), 1);
    step(2'b01, 1'b0);
    check("t1.credit2", 32'(credit), 2);
    step(2'b10, 1'b0);
    chk_out("t1.buy", 1, 0, 0, 1);
    step(2'b00, 1'b0);
    check("t1.drink_pulse", 32'(drink), 0);

    // 2: 2 + 1 + 2 = price + 1
    do_reset();
    step(2'b10, 1'b0);
    check("t2.credit2", 32'(credit), 2);
    step(2'b01, 1'b0);
    check("t2.credit3", 32'(credit), 3);
    step(2'b10, 1'b0);
`ifdef VEND_CREDIT_CARRY_EN
    chk_out("t2.buy", 1, 0, 1, 1);
`else
    chk_out("t2.buy", 1, 1, 0, 1);
`endif
    step(2'b00, 1'b0);
    check("t2.back_clear", 32'(back), 0);

    // 3: cancel refunds credit, cancel at zero refunds nothing
    do_reset();
    step(2'b01, 1'b0);
    step(2'b11, 1'b0);
    chk_out("t3.cancel", 0, 1, 0, 2);
    step(2'b11, 1'b0);
    chk_out("t3.cancel0", 0, 0, 0, 2);

    // 4: sell out, reject coins, refill
    do_reset();
    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    chk_out("t4.buy1", 1, 0, 0, 1);
    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    chk_out("t4.buy2", 1, 0, 0, 0);
    check("t4.sold_out", 32'(sold_out), 1);
    step(2'b10, 1'b0);
    chk_out("t4.reject2", 0, 2, 0, 0);
    step(2'b01, 1'b0);
    chk_out("t4.reject1", 0, 1, 0, 0);
    step(2'b10, 1'b1);
    chk_out("t4.refill_rej", 0, 2, 0, 8);
    check("t4.sold_out_clr", 32'(sold_out), 0);
    step(2'b01, 1'b0);
    chk_out("t4.accept", 0, 0, 1, 8);

    // 5: reset wins over a completing coin
    do_reset();
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    check("t5.credit3", 32'(credit), 3);
    reset = 1'b1;
    step(2'b10, 1'b0);
    reset = 1'b0;
    chk_out("t5.reset", 0, 0, 0, 2);

    // 6: refill with a completing coin keeps stock at max
    do_reset();
    step(2'b00, 1'b1);
    check("t6.refill", 32'(stock_cnt), 8);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);
    end
    check("t6.stock5", 32'(stock_cnt), 5);
    step(2'b10, 1'b0);
    check("t6.credit2", 32'(credit), 2);
    step(2'b10, 1'b1);
    chk_out("t6.buy_refill", 1, 0, 0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
